alu_issue_ctrl: RTL

//  Multi-cycle issue controller that drives the CPU's combinational ALU (A, B, ALU_operation -> Result, Zero).

---
 rtl/alu_issue_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Four-phase issue controller for the combinational ALU: accepts one
// instruction, reads its operands, drives the ALU, writes back, retires.
module alu_issue_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int LUI_SHIFT  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [31:0]           instr,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [2:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  done,
   output logic                  branch_taken,
   output logic                  illegal,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   localparam logic [5:0] OPC_R    = 6'h00;
   localparam logic [5:0] OPC_ADDI = 6'h08;
   localparam logic [5:0] OPC_LUI  = 6'h0F;
   localparam logic [5:0] OPC_BEQ  = 6'h04;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_AND = 3'd1;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_LUI = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_WB
   } state_e;

   state_e                state_q, state_d;
   logic [31:0]           instr_q;
   logic [DATA_WIDTH-1:0] rf_q [NREG];
   logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
   logic [2:0]            alu_op_q;
   logic [ADDR_WIDTH-1:0] dest_q;
   logic                  wen_q, beq_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  zero_q;

   logic                  hs;
   logic [5:0]            opcode, funct;
   logic [ADDR_WIDTH-1:0] rs, rt, rd;
   logic [15:0]           imm;
   logic [DATA_WIDTH-1:0] rs_val, rt_val;

   logic                  legal_d;
   logic [2:0]            op_d;
   logic [DATA_WIDTH-1:0] a_d, b_d;
   logic [ADDR_WIDTH-1:0] dest_d;
   logic                  wen_d, beq_d;

   logic                  unused_ok;

   assign hs     = instr_valid && instr_ready;
   assign opcode = instr_q[31:26];
   assign funct  = instr_q[5:0];
   assign rs     = instr_q[21 +: ADDR_WIDTH];
   assign rt     = instr_q[16 +: ADDR_WIDTH];
   assign rd     = instr_q[11 +: ADDR_WIDTH];
   assign imm    = instr_q[15:0];

   // reg 0 is never written, so a plain array read already returns 0 there
   assign rs_val   = rf_q[rs];
   assign rt_val   = rf_q[rt];
   assign dbg_data = rf_q[dbg_addr];

   assign unused_ok = ^instr_q[10:6];

   always_comb begin
      legal_d = 1'b1;
      op_d    = OP_ADD;
      a_d     = rs_val;
      b_d     = rt_val;
      dest_d  = rd;
      wen_d   = 1'b1;
      beq_d   = 1'b0;
      unique case (1'b1)
         (opcode == OPC_R): begin
            unique case (funct)
               6'h20:   op_d = OP_ADD;
               6'h22:   op_d = OP_SUB;
               6'h24:   op_d = OP_AND;
               6'h25:   op_d = OP_OR;
               6'h26:   op_d = OP_XOR;
               default: legal_d = 1'b0;
            endcase
         end
         (opcode == OPC_ADDI): begin
            b_d    = {{(DATA_WIDTH-16){imm[15]}}, imm};
            dest_d = rt;
         end
         (opcode == OPC_LUI): begin
            // the ALU shifts B up; the immediate spans exactly that shift
            op_d   = OP_LUI;
            a_d    = '0;
            b_d    = DATA_WIDTH'(instr_q[LUI_SHIFT-1:0]);
            dest_d = rt;
         end
         (opcode == OPC_BEQ): begin
            op_d  = OP_SUB;
            wen_d = 1'b0;
            beq_d = 1'b1;
         end
         default: legal_d = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (instr_valid) state_d = S_DECODE;
         S_DECODE: state_d = legal_d ? S_EXEC : S_IDLE;
         S_EXEC:   state_d = S_WB;
         S_WB:     state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         dest_q   <= '0;
         wen_q    <= 1'b0;
         beq_q    <= 1'b0;
         res_q    <= '0;
         zero_q   <= 1'b0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (hs) instr_q <= instr;
         if (state_q == S_DECODE && legal_d) begin
            alu_a_q  <= a_d;
            alu_b_q  <= b_d;
            alu_op_q <= op_d;
            dest_q   <= dest_d;
            wen_q    <= wen_d;
            beq_q    <= beq_d;
         end
         if (state_q == S_EXEC) begin
            res_q  <= alu_result;
            zero_q <= alu_zero;
         end
         if (state_q == S_WB && wen_q && dest_q != '0)
            rf_q[dest_q] <= res_q;
      end
   end

   assign instr_ready  = (state_q == S_IDLE);
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign done         = (state_q == S_WB);
   assign branch_taken = (state_q == S_WB) && beq_q && zero_q;
   assign illegal      = (state_q == S_DECODE) && !legal_d;

endmodule
